if_fetch_unit: RTL and testbench

//  Instruction-fetch stage controller: the consumer of the program-counter register.

---
 rtl/if_fetch_unit_pkg.sv | 15 +
 rtl/if_fetch_unit_if.sv | 22 ++
 rtl/if_fetch_unit_if_id_reg.sv | 48 ++++
 rtl/if_fetch_unit.sv | 110 +++++++++++
 tb/tb_if_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings and defaults.
package if_fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

  typedef enum logic [2:0] {
    IF_IDLE = 3'd0,
    IF_REQ  = 3'd1,
    IF_WAIT = 3'd2,
    IF_HOLD = 3'd3,
    IF_DROP = 3'd4
  } if_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response channel; master is the fetch unit.
interface if_fetch_unit_if
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              resp_valid;
  logic [31:0]       resp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module if_id_reg
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              load_i,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              valid_o,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] pc_o
);

  logic              valid_q;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
    end else if (!stall_i) begin
      if (load_i) begin
        valid_q <= 1'b1;
        inst_q  <= inst_i;
        pc_q    <= pc_i;
      end else begin
        valid_q <= 1'b0;
        inst_q  <= NOP_INST;
      end
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch controller: one outstanding imem request per PC, delivering into IF/ID.
//  state   | meaning
//  IF_IDLE | latch pc, raise request next cycle
//  IF_REQ  | request valid, waiting for ready
//  IF_WAIT | accepted, waiting for the response
//  IF_HOLD | response parked in the hold buffer while ID is stalled
//  IF_DROP | accepted but killed by a flush; swallow the response
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      pc_i,
  input  logic                   id_stall_i,
  input  logic                   flush_i,
  if_fetch_unit_if.master        imem,
  output logic                   fetch_stall_o,
  output logic                   if_id_valid_o,
  output logic [31:0]            if_id_inst_o,
  output logic [ADDR_W-1:0]      if_id_pc_o
);

  if_state_e         state_q;
  logic              req_valid_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic              kill_q;
  logic [31:0]       hold_data_q;

  logic              deliver;
  logic [31:0]       load_inst;

  assign deliver = !flush_i && !id_stall_i &&
                   ((state_q == IF_WAIT && imem.resp_valid) || state_q == IF_HOLD);
  assign load_inst     = (state_q == IF_HOLD) ? hold_data_q : imem.resp_data;
  assign fetch_stall_o = !deliver;

  // A flush in IDLE still issues the latched (stale) pc, but marks it killed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IF_IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      kill_q      <= 1'b0;
      hold_data_q <= NOP_INST;
    end else begin
      case (state_q)
        IF_IDLE: begin
          state_q     <= IF_REQ;
          req_valid_q <= 1'b1;
          req_addr_q  <= pc_i;
          kill_q      <= flush_i;
        end
        IF_REQ: begin
          if (imem.req_ready) begin
            req_valid_q <= 1'b0;
            kill_q      <= 1'b0;
            state_q     <= (kill_q || flush_i) ? IF_DROP : IF_WAIT;
          end else begin
            kill_q <= kill_q || flush_i;
          end
        end
        IF_WAIT: begin
          if (flush_i) begin
            state_q <= imem.resp_valid ? IF_IDLE : IF_DROP;
          end else if (imem.resp_valid) begin
            if (id_stall_i) begin
              hold_data_q <= imem.resp_data;
              state_q     <= IF_HOLD;
            end else begin
              state_q <= IF_IDLE;
            end
          end
        end
        IF_HOLD: begin
          if (flush_i || !id_stall_i) begin
            hold_data_q <= NOP_INST;
            state_q     <= IF_IDLE;
          end
        end
        IF_DROP: begin
          if (imem.resp_valid) state_q <= IF_IDLE;
        end
        default: state_q <= IF_IDLE;
      endcase
    end
  end

  assign imem.req_valid = req_valid_q;
  assign imem.req_addr  = req_addr_q;

  if_id_reg #(
    .ADDR_W   (ADDR_W),
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .stall_i (id_stall_i),
    .load_i  (deliver),
    .inst_i  (load_inst),
    .pc_i    (req_addr_q),
    .valid_o (if_id_valid_o),
    .inst_o  (if_id_inst_o),
    .pc_o    (if_id_pc_o)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: one task per scenario, cycle-by-cycle expectations.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] W_A = 32'h2008_0005;
  localparam logic [31:0] W_B = 32'h8C09_0004;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        id_stall;
  logic        flush;
  logic        fetch_stall;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;

  int n_vec = 0;
  int n_err = 0;

  if_fetch_unit_if #(.ADDR_W(32)) imem ();

  if_fetch_unit #(.ADDR_W(32), .NOP_INST(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc),
    .id_stall_i    (id_stall),
    .flush_i       (flush),
    .imem          (imem),
    .fetch_stall_o (fetch_stall),
    .if_id_valid_o (if_id_valid),
    .if_id_inst_o  (if_id_inst),
    .if_id_pc_o    (if_id_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic [31:0] pc_v);
    rst = 1'b1; pc = pc_v; id_stall = 1'b0; flush = 1'b0;
    imem.req_ready = 1'b0; imem.resp_valid = 1'b0; imem.resp_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pc = 32'h0; id_stall = 1'b0; flush = 1'b0;
    imem.req_ready = 1'b0; imem.resp_valid = 1'b0; imem.resp_data = 32'h0;
    #2;
    n_vec++; if (imem.req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b want 0", imem.req_valid); end
    n_vec++; if (imem.req_addr !== 32'h0) begin n_err++; $display("FAIL rst_req_addr: got %h want 0", imem.req_addr); end
    n_vec++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rst_if_id_valid: got %b want 0", if_id_valid); end
    n_vec++; if (if_id_inst !== NOP) begin n_err++; $display("FAIL rst_if_id_inst: got %h want %h", if_id_inst, NOP); end
    n_vec++; if (if_id_pc !== 32'h0) begin n_err++; $display("FAIL rst_if_id_pc: got %h want 0", if_id_pc); end
    n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL rst_fetch_stall: got %b want 1", fetch_stall); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    smp();
    n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL rst_after_fetch_stall: got %b want 1", fetch_stall); end
    n_vec++; if (imem.req_valid !== 1'b0) begin n_err++; $display("FAIL rst_after_req_valid: got %b want 0", imem.req_valid); end
  endtask

  task automatic test_basic();
    apply_reset(32'h0);
    imem.req_ready = 1'b1;
    cyc();
    smp();
    n_vec++; if (imem.req_valid !== 1'b1) begin n_err++; $display("FAIL t1_req_valid: got %b want 1", imem.req_valid); end
    n_vec++; if (imem.req_addr !== 32'h0) begin n_err++; $display("FAIL t1_req_addr: got %h want 0", imem.req_addr); end
    n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL t1_stall_req: got %b want 1", fetch_stall); end
    cyc();
    imem.resp_valid = 1'b1; imem.resp_data = W_A;
    smp();
    n_vec++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL t1_stall_deliver: got %b want 0", fetch_stall); end
    n_vec++; if (imem.req_valid !== 1'b0) begin n_err++; $display("FAIL t1_req_dropped: got %b want 0", imem.req_valid); end
    cyc();
    imem.resp_valid = 1'b0; pc = 32'h4;
    smp();
    n_vec++; if (if_id_valid !== 1'b1) begin n_err++; $display("FAIL t1_if_id_valid: got %b want 1", if_id_valid); end
    n_vec++; if (if_id_inst !== W_A) begin n_err++; $display("FAIL t1_if_id_inst: got %h want %h", if_id_inst, W_A); end
    n_vec++; if (if_id_pc !== 32'h0) begin n_err++; $display("FAIL t1_if_id_pc: got %h want 0", if_id_pc); end
    n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL t1_stall_after: got %b want 1", fetch_stall); end
    cyc();
    smp();
    n_vec++; if (imem.req_valid !== 1'b1) begin n_err++; $display("FAIL t1_next_req_valid: got %b want 1", imem.req_valid); end
    n_vec++; if (imem.req_addr !== 32'h4) begin n_err++; $display("FAIL t1_next_req_addr: got %h want 4", imem.req_addr); end
    n_vec++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin n_err++; $display("FAIL t1_bubble: got %b/%h want 0/%h", if_id_valid, if_id_inst, NOP); end
  endtask

  task automatic test_ready_wait();
    apply_reset(32'h10);
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i > 0) pc = 32'h0000_0099;
      smp();
      n_vec++; if (imem.req_valid !== 1'b1) begin n_err++; $display("FAIL t2_req_valid[%0d]: got %b want 1", i, imem.req_valid); end
      n_vec++; if (imem.req_addr !== 32'h10) begin n_err++; $display("FAIL t2_req_addr[%0d]: got %h want 10", i, imem.req_addr); end
      n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL t2_stall[%0d]: got %b want 1", i, fetch_stall); end
      n_vec++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin n_err++; $display("FAIL t2_bubble[%0d]: got %b/%h want 0/%h", i, if_id_valid, if_id_inst, NOP); end
    end
    cyc();
    imem.req_ready = 1'b1;
    smp();
    n_vec++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h10) begin n_err++; $display("FAIL t2_accept: got %b/%h want 1/10", imem.req_valid, imem.req_addr); end
    cyc();
    smp();
    n_vec++; if (imem.req_valid !== 1'b0 || fetch_stall !== 1'b1) begin n_err++; $display("FAIL t2_wait: got valid %b stall %b want 0/1", imem.req_valid, fetch_stall); end
    cyc();
    imem.resp_valid = 1'b1; imem.resp_data = 32'h1111_2222;
    smp();
    n_vec++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL t2_deliver_stall: got %b want 0", fetch_stall); end
    cyc();
    imem.resp_valid = 1'b0;
    smp();
    n_vec++; if (if_id_valid !== 1'b1 || if_id_inst !== 32'h1111_2222 || if_id_pc !== 32'h10) begin n_err++; $display("FAIL t2_load: got %b/%h/%h want 1/11112222/10", if_id_valid, if_id_inst, if_id_pc); end
  endtask

  task automatic test_id_stall();
    apply_reset(32'h0);
    imem.req_ready = 1'b1;
    cyc();
    cyc();
    imem.resp_valid = 1'b1; imem.resp_data = W_A;
    cyc();
    imem.resp_valid = 1'b0; pc = 32'h4; id_stall = 1'b1;
    smp();
    n_vec++; if (if_id_inst !== W_A || if_id_valid !== 1'b1) begin n_err++; $display("FAIL t3_first: got %b/%h want 1/%h", if_id_valid, if_id_inst, W_A); end
    cyc();
    smp();
    n_vec++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h4) begin n_err++; $display("FAIL t3_req: got %b/%h want 1/4", imem.req_valid, imem.req_addr); end
    cyc();
    imem.resp_valid = 1'b1; imem.resp_data = W_B;
    smp();
    n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL t3_stall_wait: got %b want 1", fetch_stall); end
    n_vec++; if (if_id_inst !== W_A) begin n_err++; $display("FAIL t3_hold_wait: got %h want %h", if_id_inst, W_A); end
    cyc();
    imem.resp_valid = 1'b0; imem.resp_data = 32'hFFFF_FFFF;
    smp();
    n_vec++; if (if_id_inst !== W_A || if_id_pc !== 32'h0) begin n_err++; $display("FAIL t3_hold1: got %h/%h want %h/0", if_id_inst, if_id_pc, W_A); end
    n_vec++; if (imem.req_valid !== 1'b0 || fetch_stall !== 1'b1) begin n_err++; $display("FAIL t3_no_req1: got valid %b stall %b want 0/1", imem.req_valid, fetch_stall); end
    cyc();
    id_stall = 1'b0;
    smp();
    n_vec++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL t3_release_stall: got %b want 0", fetch_stall); end
    n_vec++; if (imem.req_valid !== 1'b0 || if_id_inst !== W_A) begin n_err++; $display("FAIL t3_hold2: got valid %b inst %h want 0/%h", imem.req_valid, if_id_inst, W_A); end
    cyc();
    smp();
    n_vec++; if (if_id_valid !== 1'b1 || if_id_inst !== W_B || if_id_pc !== 32'h4) begin n_err++; $display("FAIL t3_load: got %b/%h/%h want 1/%h/4", if_id_valid, if_id_inst, if_id_pc, W_B); end
    n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL t3_stall_after: got %b want 1", fetch_stall); end
  endtask

  task automatic test_flush_wait();
    apply_reset(32'h0);
    imem.req_ready = 1'b1;
    cyc();
    cyc();
    imem.resp_valid = 1'b1; imem.resp_data = W_A;
    cyc();
    imem.resp_valid = 1'b0; pc = 32'h4; id_stall = 1'b1;
    cyc();
    cyc();
    flush = 1'b1;
    smp();
    n_vec++; if (fetch_stall !== 1'b1 || if_id_inst !== W_A) begin n_err++; $display("FAIL t4_pre_flush: got stall %b inst %h want 1/%h", fetch_stall, if_id_inst, W_A); end
    cyc();
    flush = 1'b0; id_stall = 1'b0; pc = 32'h40;
    imem.resp_valid = 1'b1; imem.resp_data = 32'hDEAD_BEEF;
    smp();
    n_vec++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin n_err++; $display("FAIL t4_flush_clear: got %b/%h want 0/%h", if_id_valid, if_id_inst, NOP); end
    n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL t4_drop_stall: got %b want 1", fetch_stall); end
    cyc();
    imem.resp_valid = 1'b0;
    smp();
    n_vec++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin n_err++; $display("FAIL t4_discard: got %b/%h want 0/%h", if_id_valid, if_id_inst, NOP); end
    n_vec++; if (imem.req_valid !== 1'b0) begin n_err++; $display("FAIL t4_idle: got %b want 0", imem.req_valid); end
    cyc();
    smp();
    n_vec++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h40) begin n_err++; $display("FAIL t4_new_req: got %b/%h want 1/40", imem.req_valid, imem.req_addr); end
    cyc();
    imem.resp_valid = 1'b1; imem.resp_data = 32'h0123_4567;
    smp();
    n_vec++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL t4_deliver_stall: got %b want 0", fetch_stall); end
    cyc();
    imem.resp_valid = 1'b0;
    smp();
    n_vec++; if (if_id_inst !== 32'h0123_4567 || if_id_pc !== 32'h40) begin n_err++; $display("FAIL t4_load: got %h/%h want 01234567/40", if_id_inst, if_id_pc); end
  endtask

  task automatic test_flush_req();
    apply_reset(32'h80);
    cyc();
    flush = 1'b1;
    smp();
    n_vec++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h80) begin n_err++; $display("FAIL t5_req: got %b/%h want 1/80", imem.req_valid, imem.req_addr); end
    cyc();
    flush = 1'b0; pc = 32'h100;
    smp();
    n_vec++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h80) begin n_err++; $display("FAIL t5_req_held: got %b/%h want 1/80", imem.req_valid, imem.req_addr); end
    cyc();
    imem.req_ready = 1'b1;
    smp();
    n_vec++; if (imem.req_valid !== 1'b1) begin n_err++; $display("FAIL t5_req_accept: got %b want 1", imem.req_valid); end
    cyc();
    smp();
    n_vec++; if (imem.req_valid !== 1'b0 || fetch_stall !== 1'b1) begin n_err++; $display("FAIL t5_drop: got valid %b stall %b want 0/1", imem.req_valid, fetch_stall); end
    cyc();
    imem.resp_valid = 1'b1; imem.resp_data = 32'hBADB_AD00;
    smp();
    n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL t5_drop_resp_stall: got %b want 1", fetch_stall); end
    cyc();
    imem.resp_valid = 1'b0;
    smp();
    n_vec++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin n_err++; $display("FAIL t5_discard: got %b/%h want 0/%h", if_id_valid, if_id_inst, NOP); end
    cyc();
    smp();
    n_vec++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h100) begin n_err++; $display("FAIL t5_new_req: got %b/%h want 1/100", imem.req_valid, imem.req_addr); end
    cyc();
    imem.resp_valid = 1'b1; imem.resp_data = 32'hCAFE_0001;
    smp();
    n_vec++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL t5_deliver_stall: got %b want 0", fetch_stall); end
    cyc();
    imem.resp_valid = 1'b0;
    smp();
    n_vec++; if (if_id_valid !== 1'b1 || if_id_inst !== 32'hCAFE_0001 || if_id_pc !== 32'h100) begin n_err++; $display("FAIL t5_load: got %b/%h/%h want 1/cafe0001/100", if_id_valid, if_id_inst, if_id_pc); end
  endtask

  task automatic test_reset_mid();
    apply_reset(32'h200);
    imem.req_ready = 1'b1;
    cyc();
    cyc();
    imem.resp_valid = 1'b1; imem.resp_data = W_A;
    cyc();
    imem.resp_valid = 1'b0; pc = 32'h204; id_stall = 1'b1;
    smp();
    n_vec++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200) begin n_err++; $display("FAIL t6_pre: got %b/%h want 1/200", if_id_valid, if_id_pc); end
    cyc();
    cyc();
    smp();
    rst = 1'b1;
    #1;
    n_vec++; if (imem.req_valid !== 1'b0 || imem.req_addr !== 32'h0) begin n_err++; $display("FAIL t6_rst_req: got %b/%h want 0/0", imem.req_valid, imem.req_addr); end
    n_vec++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP || if_id_pc !== 32'h0) begin n_err++; $display("FAIL t6_rst_if_id: got %b/%h/%h want 0/%h/0", if_id_valid, if_id_inst, if_id_pc, NOP); end
    n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL t6_rst_stall: got %b want 1", fetch_stall); end
    cyc();
    rst = 1'b0; id_stall = 1'b0;
    imem.resp_valid = 1'b1; imem.resp_data = 32'hBEEF_0000;
    smp();
    n_vec++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL t6_late_stall: got %b want 1", fetch_stall); end
    cyc();
    imem.resp_valid = 1'b0;
    smp();
    n_vec++; if (if_id_valid !== 1'b0 || if_id_inst !== NOP) begin n_err++; $display("FAIL t6_late_ignored: got %b/%h want 0/%h", if_id_valid, if_id_inst, NOP); end
    n_vec++; if (imem.req_valid !== 1'b1 || imem.req_addr !== 32'h204) begin n_err++; $display("FAIL t6_refetch: got %b/%h want 1/204", imem.req_valid, imem.req_addr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_wait();
    test_id_stall();
    test_flush_wait();
    test_flush_req();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
